pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazard classes:
- load-use data hazards (1-cycle bubble);
- taken branch/jump redirects (flush of the two younger stages);
- data-memory wait states (full freeze, with a timeout watchdog).

Parameters:
MEM_TIMEOUT, 64, maximum consecutive dmem wait cycles before the sticky error is raised (must be >= 2).
CNT_W, 7, width of the wait counter (must hold MEM_TIMEOUT).

Ports:
CLK  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
if_id_rs1  in  5  rs1 index of the instruction in ID
if_id_rs2  in  5  rs2 index of the instruction in ID
if_id_use_rs1  in  1  ID instruction reads rs1
if_id_use_rs2  in  1  ID instruction reads rs2
id_ex_rd  in  5  rd of the instruction in EX
id_ex_mem_rd  in  1  instruction in EX is a load
ex_redirect  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage holds a load/store
dmem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX load bubble (all control bits 0)
ex_mem_en  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB loads bubble (Reg_Wr_En 0)
mem_err  out  1  sticky dmem timeout error

Behaviour:
- Clocking and reset:
  - One clock, CLK. rst is asynchronous, active-high.
  - While rst=1: state=RUN, wait counter=0, mem_err=0. All outputs are driven from the RUN decode with every input treated as 0, so all enables are 1 and all flush/bubble outputs are 0.
- Output timing: outputs are combinational from the registered state plus the current inputs (zero latency). Only the state, the counter and mem_err are registered.
- Hazard conditions:
  - load_use = id_ex_mem_rd & (id_ex_rd!=0) & ((if_id_use_rs1 & id_ex_rd==if_id_rs1) | (if_id_use_rs2 & id_ex_rd==if_id_rs2)).
  - mem_stall = mem_req & ~dmem_ready.
- States: RUN, MEM_WAIT, ERROR.
- RUN / MEM_WAIT decode, strict priority:
  1. mem_stall:
     - pc_en = if_id_en = id_ex_en = ex_mem_en = 0; mem_wb_bubble = 1; flushes = 0.
     - Next state MEM_WAIT; counter increments.
  2. ex_redirect:
     - if_id_flush = 1, id_ex_flush = 1; all enables = 1.
     - load_use is ignored, because the ID instruction is on the wrong path.
  3. load_use:
     - pc_en = 0, if_id_en = 0, id_ex_flush = 1; id_ex_en = 1; ex_mem_en = 1.
  4. Otherwise: all enables 1, flush/bubble 0.
- State transitions:
  - RUN -> MEM_WAIT on mem_stall, with counter <= 1.
  - MEM_WAIT, mem_stall=1: counter++. When the counter reaches MEM_TIMEOUT-1 and the stall is still present, next state is ERROR and mem_err <= 1.
  - MEM_WAIT, dmem_ready=1: decode as RUN for this cycle (release cycle); next state RUN, counter <= 0.
- Redirect held during a freeze: ex_redirect stays asserted because EX is frozen, so it is honoured on the release cycle. It is never dropped and never applied twice.
- ERROR state:
  - All enables 0, mem_wb_bubble = 1, flushes 0, mem_err = 1.
  - Exits only through rst.
- Reset mid-operation: asynchronous rst asserted in MEM_WAIT or ERROR returns immediately to RUN and clears mem_err and the counter.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0 and wrapping at 2^32.
  - stall_cycles increments each cycle pc_en=0.
  - flush_events increments each cycle if_id_flush=1.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum: RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2;
  - REG_ZERO = 5'd0;
  - control bundle typedef {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}.
- One sub-module, load_use_detect: purely combinational load_use comparator, reused later by forwarding logic.

Test Plan:
- load_use: id_ex_mem_rd=1, id_ex_rd=5, if_id_rs2=5, if_id_use_rs2=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle.
- Same as above but id_ex_rd=0, or if_id_use_rs2=0 -> no stall, all enables 1.
- ex_redirect=1 together with load_use=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
- Memory wait with a pending redirect:
  - stimulus: mem_req=1, dmem_ready=0 for 3 cycles, then ready=1; ex_redirect=1 throughout;
  - required: 3 frozen cycles with mem_wb_bubble=1, then 1 release cycle with both flushes=1, then state RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held at 0 -> ERROR entered and mem_err=1 after 4 stall cycles; enables stay 0; rst pulse mid-ERROR -> mem_err=0 immediately, state RUN.
- PIPE_PERF_CNT_EN: run 2 load-use stalls plus 1 redirect -> stall_cycles=2, flush_events=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, register-zero index and control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
                                    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
                                    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_REDIR  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_LU     = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads a register a load in EX has not yet produced.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_use_rs1,
  input  logic       if_id_use_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_rd,
  output logic       load_use
);

  assign load_use = id_ex_mem_rd & (id_ex_rd != REG_ZERO) &
                    ((if_id_use_rs1 & (id_ex_rd == if_id_rs1)) |
                     (if_id_use_rs2 & (id_ex_rd == if_id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, redirect flush, dmem freeze with timeout.
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_use_rs1,
  input  logic       if_id_use_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_rd,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_en,
  output logic       mem_wb_bubble,
  output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  ctrl_t            ctrl;
  logic             load_use;
  logic             mem_stall;
  logic             redirect;

  // Inputs are masked during reset so the outputs show the plain RUN decode.
  assign mem_stall = ~rst & mem_req & ~dmem_ready;
  assign redirect  = ~rst & ex_redirect;

  load_use_detect u_load_use_detect (
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .if_id_use_rs1 (if_id_use_rs1),
    .if_id_use_rs2 (if_id_use_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_mem_rd  (id_ex_mem_rd & ~rst),
    .load_use      (load_use)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ERROR: ctrl = CTRL_FREEZE;
      default: begin
        if (mem_stall) begin
          ctrl = CTRL_FREEZE;
          if (state_q != MEM_WAIT) begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // A redirect held through a freeze is honoured here, on the release cycle.
          if (redirect)      ctrl = CTRL_REDIR;
          else if (load_use) ctrl = CTRL_LU;
          state_d = RUN;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign mem_err       = err_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_en)      stall_cycles <= stall_cycles + 32'd1;
      if (ctrl.if_id_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); outputs are checked mid-low-phase of CLK.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_use_rs1, if_id_use_rs2, id_ex_mem_rd, ex_redirect, mem_req, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Expected output vectors: {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_bubble,mem_err}
  localparam logic [7:0] E_RUN   = 8'b1101_0100;
  localparam logic [7:0] E_FRZ   = 8'b0000_0010;
  localparam logic [7:0] E_REDIR = 8'b1111_1100;
  localparam logic [7:0] E_LU    = 8'b0001_1100;
  localparam logic [7:0] E_ERR   = 8'b0000_0011;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(7)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .if_id_use_rs1 (if_id_use_rs1),
    .if_id_use_rs2 (if_id_use_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_mem_rd  (id_ex_mem_rd),
    .ex_redirect   (ex_redirect),
    .mem_req       (mem_req),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_en      (id_ex_en),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_err       (mem_err)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic redir,
                       input logic req, input logic rdy);
    if_id_rs1     = rs1;
    if_id_rs2     = rs2;
    if_id_use_rs1 = u1;
    if_id_use_rs2 = u2;
    id_ex_rd      = rd;
    id_ex_mem_rd  = ld;
    ex_redirect   = redir;
    mem_req       = req;
    dmem_ready    = rdy;
    #1;
  endtask

  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    // Hazards on every input while in reset must be ignored.
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    check("reset_decode", E_RUN);
    step;
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_run", E_RUN);

    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_use_rs2", E_LU);
    step;
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_released", E_RUN);
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_use_rd_zero", E_RUN);
    drive(5'd1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_use_rs2_unused", E_RUN);
    drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("load_use_rs1", E_LU);
    drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rs1_match_not_load", E_RUN);
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("redirect_over_load_use", E_REDIR);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mem_ready_no_stall", E_RUN);

    // Three-cycle freeze with a redirect waiting in EX, honoured once on release.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("freeze_c1", E_FRZ);
    step;
    check("freeze_c2", E_FRZ);
    step;
    check("freeze_c3", E_FRZ);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("release_redirect", E_REDIR);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_release_run", E_RUN);

    // Timeout: counter restarted after the release, so exactly 4 stall cycles are tolerated.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("timeout_stall_c%0d", i), E_FRZ);
      step;
    end
    check("error_entered", E_ERR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("error_ignores_ready", E_ERR);
    step;
    check("error_sticky", E_ERR);
    rst = 1'b1;
    #1;
    check("rst_mid_error", E_RUN);
    step;
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("run_after_rst", E_RUN);

    // Two load-use stalls then one redirect.
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("perf_lu1", E_LU);
    step;
    drive(5'd0, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("perf_lu2", E_LU);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("perf_redirect", E_REDIR);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check32("stall_cycles", stall_cycles, 32'd2);
    check32("flush_events", flush_events, 32'd1);
`endif

    // A short freeze after reset must release normally, not trip the watchdog.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step;
    step;
    check("short_freeze", E_FRZ);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("short_release", E_RUN);
    step;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("final_run", E_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
